// File: rtl/mwc_pkg.sv
// Shared types for the memory-write self-check monitor.
// Latency: n/a (types and constants only).
// Backpressure: none; the monitor only observes and never stalls the processor.
package mwc_pkg;

    typedef enum logic [1:0] {
        MWC_RUN  = 2'd0,
        MWC_PASS = 2'd1,
        MWC_FAIL = 2'd2
    } mwcState_e;

    typedef enum logic [1:0] {
        MWC_NONE     = 2'd0,
        MWC_MISMATCH = 2'd1,
        MWC_TIMEOUT  = 2'd2,
        MWC_DUP      = 2'd3
    } mwcFailCode_e;

    localparam int MWC_WCNT_W = 16;

endpackage

// File: rtl/mwc_timeout_ctr.sv
// Cycle watchdog: flags the edge on which the RUN-cycle count reaches TIMEOUT_CYC.
// Latency: expired is combinational on the counter, asserted during the last allowed cycle.
// Backpressure: none; counts freely while enabled.
// Ports: clk, reset (async active-low), enable (count this cycle), expired (timeout edge).
// TIMEOUT_CYC = 0 removes the counter and ties expired low.
module mwc_timeout_ctr #(
    parameter int TIMEOUT_CYC = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic expired
);

    generate
        if (TIMEOUT_CYC == 0) begin : gOff
            logic unusedOk;
            assign unusedOk = &{1'b0, clk, reset, enable};
            assign expired  = 1'b0;
        end else begin : gOn
            localparam int CW = $clog2(TIMEOUT_CYC + 1);
            localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);
            logic [CW-1:0] cycCnt;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    cycCnt <= '0;
                end else if (enable) begin
                    cycCnt <= cycCnt + 1'b1;
                end
            end

            // Fire on the edge that would move the count to TIMEOUT_CYC, so the
            // registered FAIL appears exactly TIMEOUT_CYC cycles after release.
            assign expired = enable && (cycCnt == LAST);
        end
    endgenerate

endmodule

// File: rtl/mem_write_checker.sv
// Self-check monitor on the data-memory write port: matches writes against expected pairs.
// Latency: 1 cycle from the sampling edge to registered pass/fail/status outputs.
// Backpressure: none; purely observes mem_write, never stalls the processor.
// Ports: clk, reset (async active-low), mem_write/data_adr/write_data (observed write),
//   exp_addr/exp_data (packed expected list), pass/fail/done/fail_code/fail_addr/fail_data,
//   match_cnt, write_count (saturating).
// Macro MWC_OUT_OF_ORDER_EN: expected entries may match in any order; repeats flag fail_code 3.
module mem_write_checker
    import mwc_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int NUM_EXP     = 1,
    parameter int IGN_LO      = 96,
    parameter int IGN_HI      = 96,
    parameter int TIMEOUT_CYC = 0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          mem_write,
    input  logic [ADDR_W-1:0]             data_adr,
    input  logic [DATA_W-1:0]             write_data,
    input  logic [NUM_EXP*ADDR_W-1:0]     exp_addr,
    input  logic [NUM_EXP*DATA_W-1:0]     exp_data,
    output logic                          pass,
    output logic                          fail,
    output logic                          done,
    output logic [1:0]                    fail_code,
    output logic [ADDR_W-1:0]             fail_addr,
    output logic [DATA_W-1:0]             fail_data,
    output logic [$clog2(NUM_EXP+1)-1:0]  match_cnt,
    output logic [MWC_WCNT_W-1:0]         write_count
);

    localparam int CNT_W = $clog2(NUM_EXP + 1);
    localparam logic [ADDR_W-1:0] IGN_LO_A = ADDR_W'(IGN_LO);
    localparam logic [ADDR_W-1:0] IGN_HI_A = ADDR_W'(IGN_HI);

    mwcState_e            state,     stateNxt;
    mwcFailCode_e         failCodeQ, failCodeNxt;
    logic [ADDR_W-1:0]    failAddrQ, failAddrNxt;
    logic [DATA_W-1:0]    failDataQ, failDataNxt;
    logic [CNT_W-1:0]     matchCntQ, matchCntNxt;
    logic [MWC_WCNT_W-1:0] writeCntQ, writeCntNxt;
    logic                 hit, dup, inWin, expired;
`ifdef MWC_OUT_OF_ORDER_EN
    logic [NUM_EXP-1:0]   maskQ, maskNxt;
`endif

    mwc_timeout_ctr #(.TIMEOUT_CYC(TIMEOUT_CYC)) uTimeout (
        .clk     (clk),
        .reset   (reset),
        .enable  (state == MWC_RUN),
        .expired (expired)
    );

    // An inverted window (IGN_HI < IGN_LO) can never be satisfied, which disables it.
    assign inWin = (data_adr >= IGN_LO_A) && (data_adr <= IGN_HI_A);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= MWC_RUN;
            failCodeQ <= MWC_NONE;
            failAddrQ <= '0;
            failDataQ <= '0;
            matchCntQ <= '0;
            writeCntQ <= '0;
`ifdef MWC_OUT_OF_ORDER_EN
            maskQ     <= '0;
`endif
        end else begin
            state     <= stateNxt;
            failCodeQ <= failCodeNxt;
            failAddrQ <= failAddrNxt;
            failDataQ <= failDataNxt;
            matchCntQ <= matchCntNxt;
            writeCntQ <= writeCntNxt;
`ifdef MWC_OUT_OF_ORDER_EN
            maskQ     <= maskNxt;
`endif
        end
    end

    always_comb begin
        stateNxt    = state;
        failCodeNxt = failCodeQ;
        failAddrNxt = failAddrQ;
        failDataNxt = failDataQ;
        matchCntNxt = matchCntQ;
        writeCntNxt = writeCntQ;
        hit         = 1'b0;
        dup         = 1'b0;
`ifdef MWC_OUT_OF_ORDER_EN
        maskNxt     = maskQ;
`endif
        if (state == MWC_RUN) begin
            if (mem_write) begin
                if (writeCntQ != '1) begin
                    writeCntNxt = writeCntQ + 1'b1;
                end
`ifdef MWC_OUT_OF_ORDER_EN
                // Lowest unmatched equal entry wins, so identical entries fill in order.
                for (int i = 0; i < NUM_EXP; i++) begin
                    if (!hit && !maskQ[i] &&
                        data_adr == exp_addr[i*ADDR_W +: ADDR_W] &&
                        write_data == exp_data[i*DATA_W +: DATA_W]) begin
                        hit        = 1'b1;
                        maskNxt[i] = 1'b1;
                    end
                    if (maskQ[i] &&
                        data_adr == exp_addr[i*ADDR_W +: ADDR_W] &&
                        write_data == exp_data[i*DATA_W +: DATA_W]) begin
                        dup = 1'b1;
                    end
                end
`else
                // In ordered mode the match count doubles as the next-entry index.
                for (int i = 0; i < NUM_EXP; i++) begin
                    if (matchCntQ == CNT_W'(i) &&
                        data_adr == exp_addr[i*ADDR_W +: ADDR_W] &&
                        write_data == exp_data[i*DATA_W +: DATA_W]) begin
                        hit = 1'b1;
                    end
                end
`endif
                if (hit) begin
                    matchCntNxt = matchCntQ + 1'b1;
                    if (matchCntNxt == CNT_W'(NUM_EXP)) begin
                        stateNxt = MWC_PASS;
                    end
                end else if (!inWin) begin
                    stateNxt    = MWC_FAIL;
                    failCodeNxt = dup ? MWC_DUP : MWC_MISMATCH;
                    failAddrNxt = data_adr;
                    failDataNxt = write_data;
                end
            end
            // A final match or a write failure on the timeout edge takes precedence.
            if (expired && stateNxt == MWC_RUN) begin
                stateNxt    = MWC_FAIL;
                failCodeNxt = MWC_TIMEOUT;
                failAddrNxt = '0;
                failDataNxt = '0;
            end
        end
    end

    assign pass        = (state == MWC_PASS);
    assign fail        = (state == MWC_FAIL);
    assign done        = pass | fail;
    assign fail_code   = failCodeQ;
    assign fail_addr   = failAddrQ;
    assign fail_data   = failDataQ;
    assign match_cnt   = matchCntQ;
    assign write_count = writeCntQ;

endmodule

// File: tb/tb_mem_write_checker.sv
// Directed bench for mem_write_checker: three instances (single entry, timeout, two entries).
// Latency: results checked on the falling edge after the sampling edge.
// Backpressure: none.
module tb_mem_write_checker;

    logic        clk = 1'b0;
    logic        rst1 = 1'b0, rst2 = 1'b0, rst3 = 1'b0;
    logic        memWrite = 1'b0;
    logic [31:0] dataAdr = '0, writeData = '0;

    logic p1, f1, d1, p2, f2, d2, p3, f3, d3;
    logic [1:0]  fc1, fc2, fc3;
    logic [31:0] fa1, fa2, fa3, fd1, fd2, fd3;
    logic        mc1, mc2;
    logic [1:0]  mc3;
    logic [15:0] wc1, wc2, wc3;

    int nVec = 0;
    int nMis = 0;

    always #5 clk = ~clk;

    mem_write_checker #(.NUM_EXP(1)) u1 (
        .clk(clk), .reset(rst1), .mem_write(memWrite), .data_adr(dataAdr), .write_data(writeData),
        .exp_addr(32'd100), .exp_data(32'd7),
        .pass(p1), .fail(f1), .done(d1), .fail_code(fc1), .fail_addr(fa1), .fail_data(fd1),
        .match_cnt(mc1), .write_count(wc1));

    mem_write_checker #(.NUM_EXP(1), .TIMEOUT_CYC(50)) u2 (
        .clk(clk), .reset(rst2), .mem_write(memWrite), .data_adr(dataAdr), .write_data(writeData),
        .exp_addr(32'd100), .exp_data(32'd7),
        .pass(p2), .fail(f2), .done(d2), .fail_code(fc2), .fail_addr(fa2), .fail_data(fd2),
        .match_cnt(mc2), .write_count(wc2));

    mem_write_checker #(.NUM_EXP(2)) u3 (
        .clk(clk), .reset(rst3), .mem_write(memWrite), .data_adr(dataAdr), .write_data(writeData),
        .exp_addr({32'd104, 32'd100}), .exp_data({32'd3, 32'd7}),
        .pass(p3), .fail(f3), .done(d3), .fail_code(fc3), .fail_addr(fa3), .fail_data(fd3),
        .match_cnt(mc3), .write_count(wc3));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        nVec++;
        if (obs !== expv) begin
            nMis++;
            $display("FAIL %s: got %0d want %0d", tag, obs, expv);
        end
    endtask

    task automatic resetAll();
        @(negedge clk);
        rst1 = 1'b0; rst2 = 1'b0; rst3 = 1'b0;
        repeat (2) @(negedge clk);
        rst1 = 1'b1; rst2 = 1'b1; rst3 = 1'b1;
    endtask

    // Presents one write for exactly one rising edge; returns on the following falling edge.
    task automatic doWrite(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        memWrite = 1'b1; dataAdr = a; writeData = d;
        @(negedge clk);
        memWrite = 1'b0;
    endtask

    initial begin
        // Reset state and in-order pass with ignored scratch writes.
        resetAll();
        chk("rst_pass", 32'(p1), 0);
        chk("rst_fail", 32'(f1), 0);
        chk("rst_done", 32'(d1), 0);
        chk("rst_code", 32'(fc1), 0);
        chk("rst_mcnt", 32'(mc1), 0);
        chk("rst_wcnt", 32'(wc1), 0);
        doWrite(96, 5);
        chk("ign1_wcnt", 32'(wc1), 1);
        chk("ign1_fail", 32'(f1), 0);
        doWrite(96, 9);
        doWrite(100, 7);
        chk("pass_pass", 32'(p1), 1);
        chk("pass_done", 32'(d1), 1);
        chk("pass_fail", 32'(f1), 0);
        chk("pass_wcnt", 32'(wc1), 3);
        chk("pass_mcnt", 32'(mc1), 1);
        doWrite(104, 7);
        chk("pass_frz_wcnt", 32'(wc1), 3);
        chk("pass_frz_fail", 32'(f1), 0);

        // Address mismatch, then frozen outputs.
        resetAll();
        doWrite(104, 7);
        chk("madr_fail", 32'(f1), 1);
        chk("madr_done", 32'(d1), 1);
        chk("madr_code", 32'(fc1), 1);
        chk("madr_addr", fa1, 104);
        chk("madr_data", fd1, 7);
        doWrite(100, 7);
        chk("madr_frz_pass", 32'(p1), 0);
        chk("madr_frz_wcnt", 32'(wc1), 1);

        // Data mismatch.
        resetAll();
        doWrite(100, 8);
        chk("mdat_code", 32'(fc1), 1);
        chk("mdat_data", fd1, 8);
        chk("mdat_mcnt", 32'(mc1), 0);
        chk("mdat_wcnt", 32'(wc1), 1);

        // Timeout exactly 50 cycles after release.
        resetAll();
        repeat (49) @(negedge clk);
        chk("to_early_fail", 32'(f2), 0);
        @(negedge clk);
        chk("to_fail", 32'(f2), 1);
        chk("to_code", 32'(fc2), 2);
        chk("to_addr", fa2, 0);
        chk("to_data", fd2, 0);

        // Final match on the timeout edge: pass wins.
        resetAll();
        repeat (48) @(negedge clk);
        doWrite(100, 7);
        chk("to_race_pass", 32'(p2), 1);
        chk("to_race_fail", 32'(f2), 0);
        chk("to_race_code", 32'(fc2), 0);
        repeat (3) @(negedge clk);
        chk("to_race_hold", 32'(p2), 1);

        // Two entries written in reverse order.
        resetAll();
        doWrite(104, 3);
`ifdef MWC_OUT_OF_ORDER_EN
        chk("ooo1_fail", 32'(f3), 0);
        chk("ooo1_mcnt", 32'(mc3), 1);
        doWrite(100, 7);
        chk("ooo2_pass", 32'(p3), 1);
        chk("ooo2_mcnt", 32'(mc3), 2);
`else
        chk("ord1_fail", 32'(f3), 1);
        chk("ord1_code", 32'(fc3), 1);
        chk("ord1_addr", fa3, 104);
        doWrite(100, 7);
        chk("ord2_pass", 32'(p3), 0);
`endif

        // Repeated write of the same entry.
        resetAll();
        doWrite(104, 3);
        doWrite(104, 3);
`ifdef MWC_OUT_OF_ORDER_EN
        chk("dup_code", 32'(fc3), 3);
        chk("dup_addr", fa3, 104);
        chk("dup_data", fd3, 3);
        chk("dup_wcnt", 32'(wc3), 2);
        chk("dup_mcnt", 32'(mc3), 1);
`else
        chk("dup_code", 32'(fc3), 1);
        chk("dup_wcnt", 32'(wc3), 1);
`endif

        // Mid-run reset clears immediately, then the check restarts from entry 0.
        resetAll();
        doWrite(100, 7);
        chk("mid_mcnt", 32'(mc3), 1);
        #2;
        rst3 = 1'b0;
        #1;
        chk("mid_rst_mcnt", 32'(mc3), 0);
        chk("mid_rst_wcnt", 32'(wc3), 0);
        chk("mid_rst_done", 32'(d3), 0);
        @(negedge clk);
        rst3 = 1'b1;
        doWrite(100, 7);
        doWrite(104, 3);
        chk("replay_pass", 32'(p3), 1);
        chk("replay_mcnt", 32'(mc3), 2);
        chk("replay_fail", 32'(f3), 0);
        chk("replay_wcnt", 32'(wc3), 2);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule

// File: doc/mem_write_checker.md
Name: mem_write_checker

Overview:
- Synthesizable self-check monitor on the processor's data-memory write port (mem_write / data_adr / write_data).
- Compares each write against a parametrised list of expected (address, data) pairs.
- Tolerates writes into a scratch address window; flags pass, fail or timeout.
- Sits beside the processor in simulation benches and in FPGA builds, where pass/fail drive LEDs.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- NUM_EXP, 1, number of expected write entries (>=1)
- IGN_LO, 96, lowest address of the ignored scratch window (inclusive)
- IGN_HI, 96, highest address of the ignored scratch window (inclusive; IGN_HI < IGN_LO disables the window)
- TIMEOUT_CYC, 0, cycles allowed in RUN before timeout; 0 disables timeout

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- mem_write  in  1  write strobe from the processor
- data_adr  in  ADDR_W  write address
- write_data  in  DATA_W  write data
- exp_addr  in  NUM_EXP*ADDR_W  expected addresses, entry i at bits [i*ADDR_W +: ADDR_W]
- exp_data  in  NUM_EXP*DATA_W  expected data, same packing as exp_addr
- pass  out  1  all expected writes seen
- fail  out  1  check failed
- done  out  1  pass | fail
- fail_code  out  2  0 none, 1 mismatch, 2 timeout, 3 duplicate
- fail_addr  out  ADDR_W  address of the offending write (0 on timeout)
- fail_data  out  DATA_W  data of the offending write (0 on timeout)
- match_cnt  out  $clog2(NUM_EXP+1)  expected entries matched so far
- write_count  out  16  writes accepted in RUN; saturates at 0xFFFF

Behaviour:
- Reset (async assert, sync release): state RUN; every output 0; entry index and cycle counter 0.
- States and transitions:
  - RUN -> PASS when the final expected entry matches.
  - RUN -> FAIL on mismatch, duplicate or timeout.
  - PASS and FAIL are terminal until reset. Writes in these states are ignored and every output is frozen.
- Sampling: mem_write is sampled on the rising clk edge while in RUN. Results are registered and visible the cycle after the qualifying edge (latency 1).
- Per-write priority:
  1. Match against the expected entry (ordered mode: entry[idx] only).
  2. Else, IGN_LO <= data_adr <= IGN_HI: ignored, counted only.
  3. Else: FAIL, fail_code=1, fail_addr/fail_data capture the write.
- Every write in RUN increments write_count, including the write that causes PASS or FAIL.
- Ordered mode (default): a match on entry[idx] increments idx and match_cnt. A write matching a later entry but not entry[idx] is a mismatch unless it falls in the ignore window.
- Timeout:
  - Cycle counter increments every cycle in RUN while TIMEOUT_CYC>0.
  - When the counter reaches TIMEOUT_CYC: FAIL, fail_code=2.
  - If the final match lands on the same edge as the timeout, PASS wins.
  - The counter is ADDR_W-independent and sized $clog2(TIMEOUT_CYC+1).
- Address and data compares are exact, full width; no masking.
- Reset asserted mid-run: immediate clear to reset values; the check restarts from entry 0.

Optional Feature:
- Macro MWC_OUT_OF_ORDER_EN.
- Defined:
  - A NUM_EXP-bit matched mask replaces idx. A write may match any not-yet-matched entry, which sets its bit.
  - A write equal to an already-matched entry and outside the ignore window: FAIL, fail_code=3.
  - PASS when the mask is all ones. match_cnt = popcount of the mask.
  - If two entries are identical, the lowest unmatched index is taken.
- Undefined: strict ordered mode; fail_code 3 is never produced.

Decomposition:
- Package mwc_pkg:
  - state enum (MWC_RUN, MWC_PASS, MWC_FAIL)
  - fail_code enum (MWC_NONE=0, MWC_MISMATCH=1, MWC_TIMEOUT=2, MWC_DUP=3)
  - write_count width constant (16)
- One sub-module, mwc_timeout_ctr: enable, TIMEOUT_CYC parameter, expired output; tied off when TIMEOUT_CYC=0.

Test Plan:
- NUM_EXP=1, exp (100,7), window 96..96; writes (96,5),(96,9),(100,7) -> pass=1, done=1 the cycle after the third write; write_count=3, fail=0.
- Same config; write (104,7) -> fail=1, fail_code=1, fail_addr=104, fail_data=7; a later (100,7) leaves pass=0 and write_count=1.
- Same config; write (100,8) -> fail_code=1, fail_data=8, match_cnt=0.
- TIMEOUT_CYC=50, no writes -> fail=1, fail_code=2 exactly 50 cycles after reset release. Then with (100,7) driven on cycle 50 -> pass=1, fail=0.
- NUM_EXP=2, exp (100,7),(104,3); writes (104,3),(100,7):
  - Without macro -> fail_code=1 on the first write.
  - With MWC_OUT_OF_ORDER_EN -> pass=1, match_cnt=2.
  - With macro, writes (104,3),(104,3) -> fail_code=3.
- Match (100,7) with NUM_EXP=2, then pulse reset low mid-cycle -> all outputs 0 immediately; replay (100,7),(104,3) -> pass=1.
